// File: rtl/cordic_channel_scheduler_if.sv
// Request/result handshake bundle between NCO/mixer lanes and the shared CORDIC scheduler.
// master: the lanes plus the result consumer; slave: the scheduler.
interface cordic_channel_scheduler_if #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 2,
    parameter int unsigned IW  = 12,
    parameter int unsigned OW  = 16,
    parameter int unsigned PW  = 19
);
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [NCH*IW-1:0] req_x;
    logic [NCH*IW-1:0] req_y;
    logic [NCH*PW-1:0] req_phase;
    logic              res_valid;
    logic              res_ready;
    logic [CW-1:0]     res_chan;
    logic [OW-1:0]     res_x;
    logic [OW-1:0]     res_y;

    modport master (
        output req_valid, req_x, req_y, req_phase, res_ready,
        input  req_ready, res_valid, res_chan, res_x, res_y
    );

    modport slave (
        input  req_valid, req_x, req_y, req_phase, res_ready,
        output req_ready, res_valid, res_chan, res_x, res_y
    );
endinterface

// File: rtl/cordic_channel_scheduler.sv
// Shares one pipelined CORDIC among NCH channels: round-robin grant, channel tag pipeline
// aligned to the CORDIC latency, and a registered result stage with valid/ready.
// Optional macro CORDIC_SCHED_PRIO0_EN gives channel 0 strict priority over the others.
module cordic_channel_scheduler #(
    parameter int unsigned NCH = 4,
    parameter int unsigned CW  = 2,
    parameter int unsigned IW  = 12,
    parameter int unsigned OW  = 16,
    parameter int unsigned PW  = 19,
    parameter int unsigned LAT = 18
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    cordic_channel_scheduler_if.slave io_bus,
    output logic [IW-1:0]             o_cx,
    output logic [IW-1:0]             o_cy,
    output logic [PW-1:0]             o_cphase,
    output logic                      o_cce,
    input  logic [OW-1:0]             i_rx,
    input  logic [OW-1:0]             i_ry,
    output logic                      o_busy
);
    logic           w_ce;
    logic           w_grant;
    logic [CW-1:0]  w_grant_idx;
    logic           w_rr_adv;
    logic [NCH-1:0] w_req_ready;

    logic [CW-1:0]  r_rr;
    logic [LAT-1:0] r_tag_vld;
    logic [CW-1:0]  r_tag_chan [LAT];
    logic           r_res_valid;
    logic [CW-1:0]  r_res_chan;
    logic [OW-1:0]  r_res_x;
    logic [OW-1:0]  r_res_y;

    // Whole datapath (CORDIC included) advances only when the result slot can move
    assign w_ce  = io_bus.res_ready | ~r_res_valid;
    assign o_cce = w_ce;

    // Grant search: first pending channel from the rr pointer onward, wrapping mod NCH
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        if (w_ce) begin
`ifdef CORDIC_SCHED_PRIO0_EN
            if (io_bus.req_valid[0]) begin
                w_grant     = 1'b1;
                w_grant_idx = '0;
            end
`endif
            for (int unsigned k = 0; k < NCH; k++) begin
                if (!w_grant && io_bus.req_valid[(32'(r_rr) + k) % NCH]) begin
                    w_grant     = 1'b1;
                    w_grant_idx = CW'((32'(r_rr) + k) % NCH);
                end
            end
        end
    end

`ifdef CORDIC_SCHED_PRIO0_EN
    // Channel 0 grants leave the round-robin position of the others untouched
    assign w_rr_adv = w_grant && (w_grant_idx != '0);
`else
    assign w_rr_adv = w_grant;
`endif

    // One-hot grant and CORDIC input mux; zeros when nothing is granted
    always_comb begin
        w_req_ready = '0;
        o_cx        = '0;
        o_cy        = '0;
        o_cphase    = '0;
        if (w_grant) begin
            w_req_ready[w_grant_idx] = 1'b1;
            o_cx     = io_bus.req_x[32'(w_grant_idx) * IW +: IW];
            o_cy     = io_bus.req_y[32'(w_grant_idx) * IW +: IW];
            o_cphase = io_bus.req_phase[32'(w_grant_idx) * PW +: PW];
        end
    end

    assign io_bus.req_ready = w_req_ready;

    // Round-robin pointer moves just past the channel that transferred
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rr <= '0;
        end else if (w_rr_adv) begin
            r_rr <= CW'((32'(w_grant_idx) + 1) % NCH);
        end
    end

    // Tag pipeline, frozen together with the CORDIC so tags stay aligned with its data
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tag_vld <= '0;
            for (int unsigned k = 0; k < LAT; k++) begin
                r_tag_chan[k] <= '0;
            end
        end else if (w_ce) begin
            r_tag_vld     <= {r_tag_vld[LAT-2:0], w_grant};
            r_tag_chan[0] <= w_grant_idx;
            for (int unsigned k = 1; k < LAT; k++) begin
                r_tag_chan[k] <= r_tag_chan[k-1];
            end
        end
    end

    // Result register: captures the CORDIC output with the tag leaving the pipeline
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_res_valid <= 1'b0;
            r_res_chan  <= '0;
            r_res_x     <= '0;
            r_res_y     <= '0;
        end else if (w_ce) begin
            r_res_valid <= r_tag_vld[LAT-1];
            r_res_chan  <= r_tag_chan[LAT-1];
            r_res_x     <= i_rx;
            r_res_y     <= i_ry;
        end
    end

    assign io_bus.res_valid = r_res_valid;
    assign io_bus.res_chan  = r_res_chan;
    assign io_bus.res_x     = r_res_x;
    assign io_bus.res_y     = r_res_y;
    assign o_busy           = (|r_tag_vld) | r_res_valid;
endmodule

// File: tb/tb_cordic_channel_scheduler.sv
// Scoreboard bench for cordic_channel_scheduler with a stub 18-deep CORDIC pipeline.
`timescale 1ns/1ps
module tb_cordic_channel_scheduler;
    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 2;
    localparam int unsigned IW  = 12;
    localparam int unsigned OW  = 16;
    localparam int unsigned PW  = 19;
    localparam int unsigned LAT = 18;

    typedef struct packed {
        logic [CW-1:0] chan;
        logic [OW-1:0] x;
        logic [OW-1:0] y;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [IW-1:0] cx, cy;
    logic [PW-1:0] cph;
    logic          cce;
    logic [OW-1:0] rx, ry;
    logic          busy;

    int   n_checks = 0;
    int   n_errors = 0;
    int   n_acc    = 0;
    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    cordic_channel_scheduler_if #(.NCH(NCH), .CW(CW), .IW(IW), .OW(OW), .PW(PW)) bus ();

    cordic_channel_scheduler #(
        .NCH(NCH), .CW(CW), .IW(IW), .OW(OW), .PW(PW), .LAT(LAT)
    ) dut (
        .i_clk    (clk),
        .i_reset  (rst),
        .io_bus   (bus.slave),
        .o_cx     (cx),
        .o_cy     (cy),
        .o_cphase (cph),
        .o_cce    (cce),
        .i_rx     (rx),
        .i_ry     (ry),
        .o_busy   (busy)
    );

    // Stub CORDIC transfer function, simple enough to hand-check
    function automatic logic [OW-1:0] f_rx(input logic [IW-1:0] x, input logic [PW-1:0] p);
        return {4'h0, x} + p[15:0];
    endfunction
    function automatic logic [OW-1:0] f_ry(input logic [IW-1:0] y, input logic [PW-1:0] p);
        return {4'h0, y} ^ {p[18:16], 13'h0};
    endfunction

    // Stub CORDIC: LAT enabled stages, frozen by cce
    logic [OW-1:0] m_rx [LAT];
    logic [OW-1:0] m_ry [LAT];
    always @(posedge clk) begin
        if (cce) begin
            m_rx[0] <= f_rx(cx, cph);
            m_ry[0] <= f_ry(cy, cph);
            for (int k = 1; k < int'(LAT); k++) begin
                m_rx[k] <= m_rx[k-1];
                m_ry[k] <= m_ry[k-1];
            end
        end
    end
    assign rx = m_rx[LAT-1];
    assign ry = m_ry[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Per-channel data pattern for issue slot i
    function automatic logic [IW-1:0] dx(input int n, input int i);
        return IW'(256 * (n + 1) + i);
    endfunction
    function automatic logic [IW-1:0] dy(input int n, input int i);
        return IW'(128 + 4 * i + n);
    endfunction
    function automatic logic [PW-1:0] dp(input int n, input int i);
        return PW'((n << 16) | (i * 37));
    endfunction

    task automatic set_raw(input int n, input logic [IW-1:0] x, input logic [IW-1:0] y,
                           input logic [PW-1:0] p);
        bus.req_x[n*IW +: IW]     = x;
        bus.req_y[n*IW +: IW]     = y;
        bus.req_phase[n*PW +: PW] = p;
    endtask

    task automatic push_raw(input int ch, input logic [IW-1:0] x, input logic [IW-1:0] y,
                            input logic [PW-1:0] p);
        exp_t e;
        e.chan = CW'(ch);
        e.x    = f_rx(x, p);
        e.y    = f_ry(y, p);
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        bus.req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        q.delete();
    endtask

    // cnt grants with all channels requesting; order assumes rr starts at 0
    task automatic issue_rr(input int cnt, input string name);
        for (int i = 0; i < cnt; i++) begin
            for (int n = 0; n < int'(NCH); n++) set_raw(n, dx(n, i), dy(n, i), dp(n, i));
            bus.req_valid = '1;
            push_raw(i % NCH, dx(i % NCH, i), dy(i % NCH, i), dp(i % NCH, i));
            @(negedge clk);
            check(name, 32'(bus.req_ready), 32'(1 << (i % NCH)));
            tick();
        end
        bus.req_valid = '0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(q.size()), 32'd0);
        tick();
    endtask

    // Monitor: every accepted result must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            n_acc++;
            if (q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got chan %0d x 0x%0h, expected none",
                         bus.res_chan, bus.res_x);
            end else begin
                mon_e = q.pop_front();
                check("res_chan", 32'(bus.res_chan), 32'(mon_e.chan));
                check("res_x", 32'(bus.res_x), 32'(mon_e.x));
                check("res_y", 32'(bus.res_y), 32'(mon_e.y));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int acc0;
        int seen;
        bus.req_valid = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.req_phase = '0;
        bus.res_ready = 1'b1;
        rst           = 1'b1;
        repeat (3) tick();

        // Reset state
        @(negedge clk);
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_chan", 32'(bus.res_chan), 32'd0);
        check("rst_res_x", 32'(bus.res_x), 32'd0);
        check("rst_res_y", 32'(bus.res_y), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cce", 32'(cce), 32'd1);
        tick();
        rst = 1'b0;

        // Single request on ch2: same-cycle grant, result 19 cycles later
        set_raw(2, 12'h100, 12'h000, 19'h0);
        bus.req_valid = 4'b0100;
        push_raw(2, 12'h100, 12'h000, 19'h0);
        @(negedge clk);
        check("t1_ready", 32'(bus.req_ready), 32'h4);
        check("t1_cx", 32'(cx), 32'h100);
        check("t1_cphase", 32'(cph), 32'h0);
        tick();
        bus.req_valid = '0;
        n = 1;
        @(negedge clk);
        while (!bus.res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("t1_latency", 32'(n), 32'd19);
        check("t1_busy_hi", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_busy_fall", 32'(busy), 32'd0);
        drain("t1_drain");

        // Full load: grant order 0,1,2,3,... and back-to-back results
        apply_reset();
        issue_rr(8, "t2_grant");
        n = 0;
        @(negedge clk);
        while (!bus.res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 8; i++) begin
            check("t2_b2b_valid", 32'(bus.res_valid), 32'd1);
            @(negedge clk);
        end
        drain("t2_drain");

        // Backpressure: 5 stalled cycles freeze everything
        apply_reset();
        acc0 = n_acc;
        issue_rr(4, "t3_grant");
        n = 0;
        while (!bus.res_valid && n < 40) begin
            tick();
            n++;
        end
        bus.res_ready = 1'b0;
        set_raw(0, 12'h7AB, 12'h055, 19'h1);
        bus.req_valid = 4'b0001;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("t3_cce", 32'(cce), 32'd0);
            check("t3_no_grant", 32'(bus.req_ready), 32'd0);
            check("t3_hold_valid", 32'(bus.res_valid), 32'd1);
            check("t3_hold_chan", 32'(bus.res_chan), 32'd0);
            check("t3_hold_x", 32'(bus.res_x), 32'h0100);
            tick();
        end
        bus.res_ready = 1'b1;
        bus.req_valid = '0;
        drain("t3_drain");
        check("t3_count", 32'(n_acc - acc0), 32'd4);

        // Wrap: rr = 2 with ch1 and ch3 pending -> ch3 then ch1
        apply_reset();
        set_raw(1, 12'h011, 12'h022, 19'h00033);
        bus.req_valid = 4'b0010;
        push_raw(1, 12'h011, 12'h022, 19'h00033);
        @(negedge clk);
        check("t4_setup", 32'(bus.req_ready), 32'h2);
        tick();
        set_raw(1, 12'h111, 12'h122, 19'h40000);
        set_raw(3, 12'h333, 12'h344, 19'h7FFFF);
        bus.req_valid = 4'b1010;
        push_raw(3, 12'h333, 12'h344, 19'h7FFFF);
        @(negedge clk);
        check("t4_first_ch3", 32'(bus.req_ready), 32'h8);
        tick();
        push_raw(1, 12'h111, 12'h122, 19'h40000);
        @(negedge clk);
        check("t4_then_ch1", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = '0;
        drain("t4_drain");

        // ch0 and ch1 both requesting continuously
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            set_raw(0, dx(0, i), dy(0, i), dp(0, i));
            set_raw(1, dx(1, i), dy(1, i), dp(1, i));
            bus.req_valid = 4'b0011;
`ifdef CORDIC_SCHED_PRIO0_EN
            push_raw(0, dx(0, i), dy(0, i), dp(0, i));
            @(negedge clk);
            check("t6_prio_ch0", 32'(bus.req_ready), 32'h1);
`else
            push_raw(i % 2, dx(i % 2, i), dy(i % 2, i), dp(i % 2, i));
            @(negedge clk);
            check("t6_alternate", 32'(bus.req_ready), 32'(1 << (i % 2)));
`endif
            tick();
        end
        set_raw(1, 12'h5A5, 12'h0A0, 19'h2AAAA);
        bus.req_valid = 4'b0010;
        push_raw(1, 12'h5A5, 12'h0A0, 19'h2AAAA);
        @(negedge clk);
        check("t6_ch1_after", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = '0;
        drain("t6_drain");

        // Reset with results emerging and many more in flight
        apply_reset();
        issue_rr(24, "t5_grant");
        check("t5_pre_valid", 32'(bus.res_valid), 32'd1);
        check("t5_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        q.delete();
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t5_post_valid", 32'(bus.res_valid), 32'd0);
        check("t5_post_busy", 32'(busy), 32'd0);
        check("t5_post_x", 32'(bus.res_x), 32'd0);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.res_valid) seen++;
        end
        check("t5_no_results", 32'(seen), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
